// File: rtl/vm_pkg.sv
// Shared types and default coin table for the change dispenser.
package vm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC     = 3'd1,
    SELECT   = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int AMT_W_DEF    = 8;
  localparam int NUM_COIN_DEF = 3;

  typedef logic [$clog2(NUM_COIN_DEF)-1:0] coin_idx_t;

  // Index 0 is the smallest coin; values strictly ascend with index.
  localparam logic [NUM_COIN_DEF*AMT_W_DEF-1:0] COIN_VAL_DEF = {8'd10, 8'd5, 8'd1};

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the vending FSM / hopper driver (master) and the change dispenser (slave).
interface change_dispenser_if #(
  parameter int AMT_W    = 8,
  parameter int NUM_COIN = 3,
  parameter int STOCK_W  = 6
) ();
  logic [AMT_W-1:0]            current_amount_display;
  logic [AMT_W-1:0]            product_price;
  logic                        change_calculator_en;
  logic                        coin_ack;
  logic                        restock_en;
  logic [$clog2(NUM_COIN)-1:0] restock_idx;
  logic [STOCK_W-1:0]          restock_cnt;
  logic [AMT_W-1:0]            change_out;
  logic [AMT_W-1:0]            change_remaining;
  logic [NUM_COIN-1:0]         coin_req;
  logic                        change_calculator_done;
  logic                        change_short;
  logic                        hopper_fault;
  logic                        underpay;
  logic                        busy;

  modport master (
    output current_amount_display, product_price, change_calculator_en, coin_ack,
           restock_en, restock_idx, restock_cnt,
    input  change_out, change_remaining, coin_req, change_calculator_done,
           change_short, hopper_fault, underpay, busy
  );

  modport slave (
    input  current_amount_display, product_price, change_calculator_en, coin_ack,
           restock_en, restock_idx, restock_cnt,
    output change_out, change_remaining, coin_req, change_calculator_done,
           change_short, hopper_fault, underpay, busy
  );
endinterface

// File: rtl/coin_selector.sv
// Greedy pick: highest-index coin that fits the remaining change and is in stock.
module coin_selector #(
  parameter int AMT_W    = 8,
  parameter int NUM_COIN = 3,
  parameter int STOCK_W  = 6
) (
  input  logic [AMT_W-1:0]                remaining_i,
  input  logic [NUM_COIN*AMT_W-1:0]       coin_val_i,
  input  logic [NUM_COIN-1:0][STOCK_W-1:0] stock_i,
  output logic                            found_o,
  output logic [NUM_COIN-1:0]             onehot_o
);

  // Later (larger) indices overwrite earlier hits, so the largest coin wins.
  always_comb begin
    found_o  = 1'b0;
    onehot_o = '0;
    for (int i = 0; i < NUM_COIN; i++) begin
      if ((coin_val_i[i*AMT_W +: AMT_W] <= remaining_i) && (stock_i[i] != '0)) begin
        found_o  = 1'b1;
        onehot_o = NUM_COIN'(1) << i;
      end else begin
        onehot_o = onehot_o;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Computes change owed and pays it out coin by coin over a req/ack hopper handshake.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int                          AMT_W       = 8,
  parameter int                          NUM_COIN    = 3,
  parameter logic [NUM_COIN*AMT_W-1:0]   COIN_VAL    = COIN_VAL_DEF,
  parameter int                          STOCK_W     = 6,
  parameter int                          INIT_STOCK  = 10,
  parameter int                          ACK_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);

  localparam int                 IDX_W     = $clog2(NUM_COIN);
  localparam int                 TMR_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  state_t                           state_q, state_d;
  logic [AMT_W-1:0]                 paid_q, paid_d, price_q, price_d;
  logic [AMT_W-1:0]                 change_out_q, change_out_d;
  logic [AMT_W-1:0]                 remaining_q, remaining_d;
  logic [NUM_COIN-1:0]              pick_q, pick_d, req_q, req_d;
  logic [TMR_W-1:0]                 timer_q, timer_d;
  logic                             short_q, short_d, fault_q, fault_d;
  logic                             underpay_q, underpay_d, done_q, busy_q;
  logic [NUM_COIN-1:0][STOCK_W-1:0] stock_q, stock_d;
  logic                             found_s, ack_take_s;
  logic [NUM_COIN-1:0]              sel_s;
  logic [AMT_W-1:0]                 pick_val_s;

  coin_selector #(.AMT_W(AMT_W), .NUM_COIN(NUM_COIN), .STOCK_W(STOCK_W)) u_sel (
    .remaining_i (remaining_q),
    .coin_val_i  (COIN_VAL),
    .stock_i     (stock_q),
    .found_o     (found_s),
    .onehot_o    (sel_s)
  );

  // Value of the coin currently being requested.
  always_comb begin
    pick_val_s = '0;
    for (int i = 0; i < NUM_COIN; i++) begin
      if (pick_q[i]) begin
        pick_val_s = pick_val_s | COIN_VAL[i*AMT_W +: AMT_W];
      end else begin
        pick_val_s = pick_val_s;
      end
    end
  end

  // Transaction FSM: next state and datapath updates.
  always_comb begin
    state_d      = state_q;
    paid_d       = paid_q;
    price_d      = price_q;
    change_out_d = change_out_q;
    remaining_d  = remaining_q;
    pick_d       = pick_q;
    req_d        = '0;
    timer_d      = timer_q;
    short_d      = short_q;
    fault_d      = fault_q;
    underpay_d   = underpay_q;
    ack_take_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.change_calculator_en) begin
          paid_d     = bus.current_amount_display;
          price_d    = bus.product_price;
          short_d    = 1'b0;
          fault_d    = 1'b0;
          underpay_d = 1'b0;
          state_d    = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (paid_q >= price_q) begin
          change_out_d = paid_q - price_q;
          remaining_d  = paid_q - price_q;
        end else begin
          change_out_d = paid_q;
          remaining_d  = paid_q;
          underpay_d   = 1'b1;
        end
        state_d = SELECT;
      end
      SELECT: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (found_s) begin
          pick_d  = sel_s;
          timer_d = '0;
          state_d = WAIT_ACK;
        end else begin
          short_d = 1'b1;
          state_d = DONE;
        end
      end
      // coin_req rises one cycle into WAIT_ACK and is held while the timer runs.
      WAIT_ACK: begin
        if (bus.coin_ack) begin
          ack_take_s  = 1'b1;
          remaining_d = remaining_q - pick_val_s;
          state_d     = SELECT;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT)) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          req_d   = pick_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stock update: restock and dispense may hit the same counter in one cycle.
  always_comb begin
    logic [STOCK_W:0] sum;
    for (int i = 0; i < NUM_COIN; i++) begin
      sum = {1'b0, stock_q[i]};
      if (bus.restock_en && (bus.restock_idx == IDX_W'(i))) begin
        sum = sum + {1'b0, bus.restock_cnt};
      end else begin
        sum = sum;
      end
      if (ack_take_s && pick_q[i] && (stock_q[i] != '0)) begin
        sum = sum - (STOCK_W+1)'(1);
      end else begin
        sum = sum;
      end
      stock_d[i] = (sum > {1'b0, STOCK_MAX}) ? STOCK_MAX : sum[STOCK_W-1:0];
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      paid_q       <= '0;
      price_q      <= '0;
      change_out_q <= '0;
      remaining_q  <= '0;
      pick_q       <= '0;
      req_q        <= '0;
      timer_q      <= '0;
      short_q      <= 1'b0;
      fault_q      <= 1'b0;
      underpay_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NUM_COIN; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q      <= state_d;
      paid_q       <= paid_d;
      price_q      <= price_d;
      change_out_q <= change_out_d;
      remaining_q  <= remaining_d;
      pick_q       <= pick_d;
      req_q        <= req_d;
      timer_q      <= timer_d;
      short_q      <= short_d;
      fault_q      <= fault_d;
      underpay_q   <= underpay_d;
      done_q       <= (state_q == DONE);
      busy_q       <= (state_d != IDLE);
      stock_q      <= stock_d;
    end
  end

  assign bus.change_out             = change_out_q;
  assign bus.change_remaining       = remaining_q;
  assign bus.coin_req               = req_q;
  assign bus.change_calculator_done = done_q;
  assign bus.change_short           = short_q;
  assign bus.hopper_fault           = fault_q;
  assign bus.underpay               = underpay_q;
  assign bus.busy                   = busy_q;

endmodule
